prog_sequencer: RTL

- Run controller for the basic processor's instruction fetch stage. It sequences program execution for the fetch stage and the rest of the datapath.
- It accepts a start request for one of three resident programs and holds fetch in init while idle. It forces a jump to the selected program's base address, then lets fetch run.
- It ends the run on the fetch Halt flag, an abort, or a cycle-budget timeout, and reports the outcome and the cycle count.

---
 rtl/prog_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// Run controller for the fetch stage: launches one of three resident programs,
// then watches for Halt, Abort or budget exhaustion and reports the outcome.
module prog_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned PROG0_BASE = 0,
  parameter int unsigned PROG1_BASE = 256,
  parameter int unsigned PROG2_BASE = 512
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Abort,
  input  logic             Halt_in,
  output logic             Init,
  output logic             Force_jump,
  output logic [PC_W-1:0]  Jump_target,
  output logic [1:0]       ProgState,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic             Err,
  output logic [CYC_W-1:0] CycleCount
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q;
  logic [PC_W-1:0]  jump_target_q;
  logic [1:0]       prog_state_q;
  logic             done_q;
  logic             timeout_q;
  logic             err_q;
  logic [CYC_W-1:0] cycle_q;

  function automatic logic [PC_W-1:0] prog_base(input logic [1:0] sel);
    case (sel)
      2'd1:    prog_base = PC_W'(PROG1_BASE);
      2'd2:    prog_base = PC_W'(PROG2_BASE);
      default: prog_base = PC_W'(PROG0_BASE);
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      jump_target_q <= '0;
      prog_state_q  <= 2'd0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      err_q         <= 1'b0;
      cycle_q       <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (ProgSel != 2'd3) begin
              // Target is loaded here so it is already valid during LOAD.
              prog_state_q  <= ProgSel;
              jump_target_q <= prog_base(ProgSel);
              cycle_q       <= '0;
              err_q         <= 1'b0;
              state_q       <= StLoad;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StLoad: state_q <= StRun;
        StRun: begin
          if (Abort) begin
            state_q <= StIdle;
          end else if (Halt_in) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            cycle_q   <= CYC_W'(MAX_CYCLES);
            state_q   <= StDone;
          end else begin
            cycle_q <= cycle_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Init        = (state_q == StIdle) || (state_q == StDone);
  assign Busy        = (state_q == StLoad) || (state_q == StRun);
  assign Force_jump  = (state_q == StLoad);
  assign Jump_target = jump_target_q;
  assign ProgState   = prog_state_q;
  assign Done        = done_q;
  assign Timeout     = timeout_q;
  assign Err         = err_q;
  assign CycleCount  = cycle_q;

endmodule
